ycr_dcache_req_pipe: RTL and testbench
======================================

Name: ycr_dcache_req_pipe

Overview:
- Request decoupling stage directly downstream of the dcache router, upstream of the dcache core.
- Buffers router requests in a small in-order FIFO and presents them to the cache with a registered request handshake.
- Tracks outstanding cache transactions, limits them, and returns responses in order to the router side.

Parameters:
- DEPTH, 2, request FIFO entries; power of two, 2..8.
- MAX_PEND, 4, maximum FIFO entries plus outstanding cache transactions; must be >= DEPTH.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- req_ack  output  1  upstream request accepted this cycle.
- req  input  1  upstream request valid.
- cmd  input  1  0 = read, 1 = write.
- width  input  2  byte / hword / word.
- addr  input  `YCR_IMEM_AWIDTH  upstream address.
- wdata  input  `YCR_IMEM_DWIDTH  upstream write data.
- rdata  output  `YCR_IMEM_DWIDTH  read data back to upstream.
- resp  output  2  upstream response code (memif encoding).
- mem_req_ack  input  1  cache accepted request.
- mem_req  output  1  request to cache.
- mem_cmd  output  1  head-entry cmd.
- mem_width  output  2  head-entry width.
- mem_addr  output  `YCR_IMEM_AWIDTH  head-entry address.
- mem_wdata  output  `YCR_IMEM_DWIDTH  head-entry write data.
- mem_rdata  input  `YCR_IMEM_DWIDTH  cache read data.
- mem_resp  input  2  cache response code.
- unexp_resp  output  1  sticky flag: response received with zero outstanding.

Behaviour:
- Reset, asynchronous: FIFO pointers and count = 0; outstanding = 0; unexp_resp = 0.
- Reset values of outputs:
  - mem_req = 0 and req_ack = 0.
  - resp = NOTRDY and rdata = 0.
  - mem_cmd/width/addr/wdata = 0.
- Reset during a transaction discards all entries and all in-flight tracking. There is no replay.
- Accept rule: req_ack = req && (fifo_cnt < DEPTH) && (fifo_cnt + outstanding < MAX_PEND). It is combinational in the same cycle.
- A push happens on req && req_ack, and all request fields are captured into the tail entry.
- The FIFO has no bypass. A request pushed into an empty FIFO appears on mem_req on the next cycle, giving 1-cycle minimum added latency.
- Downstream side:
  - mem_req = (fifo_cnt != 0).
  - mem_* fields come from the head entry (registered FIFO storage).
  - Fields hold stable while mem_req is high and mem_req_ack is low.
  - A pop happens on mem_req && mem_req_ack, and outstanding increments.
- Response:
  - Any mem_resp != NOTRDY (RDY_OK or RDY_ER) is a completion, and outstanding decrements.
  - resp = mem_resp and rdata = mem_rdata. This is a combinational passthrough in the default build.
  - RDY_ER is forwarded unchanged.
- Simultaneous events:
  - Push and pop in the same cycle leave fifo_cnt unchanged. This is allowed when not full.
  - When full, a push is refused even if a pop occurs that cycle.
  - A pop and a completion in the same cycle leave outstanding unchanged.
  - MAX_PEND is evaluated on registered counts, so a same-cycle completion does not free a slot until the next cycle.
- Boundary cases:
  - A completion with outstanding == 0 sets unexp_resp. outstanding stays 0, and resp is still forwarded.
  - Pointers wrap modulo DEPTH.
- No state machine beyond the counters. The FIFO is either empty, partial or full, derived from fifo_cnt.

Optional Feature:
- Macro: YCR_DCACHE_PIPE_RESP_REG_EN.
- When defined:
  - resp and rdata are registered, adding 1 cycle of response latency.
  - resp is NOTRDY in every cycle without a registered completion.
  - outstanding decrements when mem_resp is sampled, not at output.
- When undefined: combinational passthrough as described above.

Decomposition:
- Shared package ycr_dcache_pkg holds:
  - the request struct type_ycr_dcache_req_s (cmd, width, addr, wdata);
  - the memif response encodings, reused from the memif header;
  - the DEPTH/MAX_PEND defaults.
- One sub-module: ycr_dcache_req_fifo. It is a parametric struct-wide sync FIFO with push/pop/count/full/empty on clk/rst_n.

Test Plan:
- Single read:
  - Stimulus: req=1, cmd=0, addr=0x0000_1000, FIFO empty.
  - Required: req_ack=1 in the same cycle; mem_req=1 next cycle with mem_addr=0x1000.
  - After mem_req_ack and mem_resp=RDY_OK, mem_rdata=0xDEAD_BEEF: resp=RDY_OK and rdata=0xDEADBEEF in the same cycle.
- Backpressure fill (DEPTH=2):
  - Stimulus: mem_req_ack=0 and three back-to-back requests.
  - Required: first two are acked; third sees req_ack=0. mem_addr holds entry 0 stable.
- MAX_PEND limit (MAX_PEND=4):
  - Stimulus: 4 requests issued and acked by the cache with no responses returned.
  - Required: 5th req_ack=0 until one RDY_OK arrives, then accepted on the following cycle.
- Simultaneous push/pop/completion:
  - Stimulus: fifo_cnt=1, outstanding=1, with req, mem_req_ack and RDY_OK all in one cycle.
  - Required: counts stay 1/1 next cycle, and ordering is preserved (addresses 0x10, 0x20, 0x30 complete in order).
- Error and unexpected response:
  - RDY_ER on an outstanding write is forwarded as resp=RDY_ER.
  - RDY_OK with outstanding=0 sets unexp_resp=1 and it stays set.
- Reset mid-operation:
  - Stimulus: rst_n low while 2 entries are queued and 1 is outstanding.
  - Required: mem_req=0, req_ack=0 and unexp_resp=0 immediately (asynchronous reset).
  - After release, a fresh request completes normally.
  - With YCR_DCACHE_PIPE_RESP_REG_EN defined, rerun the single-read scenario: resp must appear one cycle later.

Source files
------------

// File: rtl/ycr_dcache_pkg.sv
// Shared types and defaults for the dcache request pipe: request struct,
// memif response/width encodings and default queue sizing.
`ifndef YCR_IMEM_AWIDTH
`define YCR_IMEM_AWIDTH 32
`endif
`ifndef YCR_IMEM_DWIDTH
`define YCR_IMEM_DWIDTH 32
`endif

package ycr_dcache_pkg;

   localparam int YCR_DCACHE_DEPTH_DEF    = 2;
   localparam int YCR_DCACHE_MAX_PEND_DEF = 4;

   typedef enum logic [1:0] {
      YCR_MEM_RESP_NOTRDY = 2'b00,
      YCR_MEM_RESP_RDY_OK = 2'b01,
      YCR_MEM_RESP_RDY_ER = 2'b10
   } type_ycr_mem_resp_e;

   typedef enum logic [1:0] {
      YCR_MEM_WIDTH_BYTE  = 2'b00,
      YCR_MEM_WIDTH_HWORD = 2'b01,
      YCR_MEM_WIDTH_WORD  = 2'b10,
      YCR_MEM_WIDTH_ERROR = 2'b11
   } type_ycr_mem_width_e;

   typedef struct packed {
      logic                        cmd;
      logic [1:0]                  width;
      logic [`YCR_IMEM_AWIDTH-1:0] addr;
      logic [`YCR_IMEM_DWIDTH-1:0] wdata;
   } type_ycr_dcache_req_s;

endpackage

// File: rtl/ycr_dcache_req_fifo.sv
// In-order request FIFO, one packed request struct per entry; head is read
// straight from registered storage, so there is no push-to-pop bypass.
module ycr_dcache_req_fifo
   import ycr_dcache_pkg::*;
#(
   parameter int DEPTH = YCR_DCACHE_DEPTH_DEF
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  type_ycr_dcache_req_s         din,
   input  logic                         pop,
   output type_ycr_dcache_req_s         dout,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   type_ycr_dcache_req_s mem [DEPTH];
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic                 do_push;
   logic                 do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Storage is cleared too, so the head fields read as zero out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

endmodule

// File: rtl/ycr_dcache_req_pipe.sv
// Request decoupling stage between dcache router and dcache core.
// Optional macro YCR_DCACHE_PIPE_RESP_REG_EN registers resp/rdata (+1 cycle).
module ycr_dcache_req_pipe
   import ycr_dcache_pkg::*;
#(
   parameter int DEPTH    = YCR_DCACHE_DEPTH_DEF,
   parameter int MAX_PEND = YCR_DCACHE_MAX_PEND_DEF
) (
   input  logic                        clk,
   input  logic                        rst_n,
   output logic                        req_ack,
   input  logic                        req,
   input  logic                        cmd,
   input  logic [1:0]                  width,
   input  logic [`YCR_IMEM_AWIDTH-1:0] addr,
   input  logic [`YCR_IMEM_DWIDTH-1:0] wdata,
   output logic [`YCR_IMEM_DWIDTH-1:0] rdata,
   output logic [1:0]                  resp,
   input  logic                        mem_req_ack,
   output logic                        mem_req,
   output logic                        mem_cmd,
   output logic [1:0]                  mem_width,
   output logic [`YCR_IMEM_AWIDTH-1:0] mem_addr,
   output logic [`YCR_IMEM_DWIDTH-1:0] mem_wdata,
   input  logic [`YCR_IMEM_DWIDTH-1:0] mem_rdata,
   input  logic [1:0]                  mem_resp,
   output logic                        unexp_resp
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int OW = $clog2(MAX_PEND+1);

   type_ycr_dcache_req_s tail;
   type_ycr_dcache_req_s head;
   logic [CW-1:0]        fifo_cnt;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [OW-1:0]        outstanding;
   logic                 push;
   logic                 pop;
   logic                 completion;
   logic                 retire;

   assign tail = '{cmd: cmd, width: width, addr: addr, wdata: wdata};

   // Limit is checked on registered counts only; a completion frees its slot next cycle.
   assign req_ack = rst_n && req && !fifo_full
                    && ((int'(fifo_cnt) + int'(outstanding)) < MAX_PEND);
   assign push    = req && req_ack;
   assign mem_req = !fifo_empty;
   assign pop     = mem_req && mem_req_ack;

   ycr_dcache_req_fifo #(.DEPTH(DEPTH)) i_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (tail),
      .pop   (pop),
      .dout  (head),
      .count (fifo_cnt),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign mem_cmd   = head.cmd;
   assign mem_width = head.width;
   assign mem_addr  = head.addr;
   assign mem_wdata = head.wdata;

   assign completion = (mem_resp != YCR_MEM_RESP_NOTRDY);
   assign retire     = completion && (outstanding != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding <= '0;
         unexp_resp  <= 1'b0;
      end else begin
         if (completion && (outstanding == '0)) unexp_resp <= 1'b1;
         case ({pop, retire})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: ;
         endcase
      end
   end

`ifdef YCR_DCACHE_PIPE_RESP_REG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp  <= YCR_MEM_RESP_NOTRDY;
         rdata <= '0;
      end else begin
         resp  <= mem_resp;
         rdata <= mem_rdata;
      end
   end
`else
   assign resp  = mem_resp;
   assign rdata = mem_rdata;
`endif

endmodule

// File: tb/tb_ycr_dcache_req_pipe.sv
// Directed plus randomized bench for ycr_dcache_req_pipe against a queue-based model.
`ifndef YCR_IMEM_AWIDTH
`define YCR_IMEM_AWIDTH 32
`endif
`ifndef YCR_IMEM_DWIDTH
`define YCR_IMEM_DWIDTH 32
`endif

module tb_ycr_dcache_req_pipe;

   localparam int AW       = `YCR_IMEM_AWIDTH;
   localparam int DW       = `YCR_IMEM_DWIDTH;
   localparam int DEPTH    = 2;
   localparam int MAX_PEND = 4;
   localparam logic [1:0] NOTRDY = 2'b00;
   localparam logic [1:0] RDY_OK = 2'b01;
   localparam logic [1:0] RDY_ER = 2'b10;

   typedef struct {
      logic          cmd;
      logic [1:0]    width;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } ent_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_ack;
   logic          req = 1'b0;
   logic          cmd = 1'b0;
   logic [1:0]    width = 2'b00;
   logic [AW-1:0] addr = '0;
   logic [DW-1:0] wdata = '0;
   logic [DW-1:0] rdata;
   logic [1:0]    resp;
   logic          mem_req_ack = 1'b0;
   logic          mem_req;
   logic          mem_cmd;
   logic [1:0]    mem_width;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic [1:0]    mem_resp = 2'b00;
   logic          unexp_resp;

   ycr_dcache_req_pipe #(.DEPTH(DEPTH), .MAX_PEND(MAX_PEND)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_ack     (req_ack),
      .req         (req),
      .cmd         (cmd),
      .width       (width),
      .addr        (addr),
      .wdata       (wdata),
      .rdata       (rdata),
      .resp        (resp),
      .mem_req_ack (mem_req_ack),
      .mem_req     (mem_req),
      .mem_cmd     (mem_cmd),
      .mem_width   (mem_width),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_resp    (mem_resp),
      .unexp_resp  (unexp_resp)
   );

   always #5 clk = ~clk;

   int            ncmp = 0;
   int            nfail = 0;
   ent_t          fq[$];
   ent_t          oq[$];
   logic          exp_unexp;
   logic [1:0]    prev_resp;
   logic [DW-1:0] prev_rdata;
   logic          obs_ack;
   logic [1:0]    obs_resp;
   logic [DW-1:0] obs_rdata;
   logic          acks[8];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      fq.delete();
      oq.delete();
      exp_unexp  = 1'b0;
      prev_resp  = NOTRDY;
      prev_rdata = '0;
   endtask

   task automatic set_in(input logic r, input logic c, input logic [1:0] w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic mack, input logic [1:0] mresp, input logic [DW-1:0] mrd);
      req = r; cmd = c; width = w; addr = a; wdata = d;
      mem_req_ack = mack; mem_resp = mresp; mem_rdata = mrd;
   endtask

   // Called at posedge+1 with inputs driven; returns at the next posedge+1.
   task automatic cycle();
      logic exp_ack;
      logic do_pop;
      ent_t cur;
      exp_ack = rst_n && req && (fq.size() < DEPTH) && ((fq.size() + oq.size()) < MAX_PEND);
      do_pop  = (fq.size() != 0) && mem_req_ack;
      cur.cmd = cmd; cur.width = width; cur.addr = addr; cur.wdata = wdata;
      #1;
      obs_ack = req_ack;
      chk("req_ack", req_ack, exp_ack);
`ifndef YCR_DCACHE_PIPE_RESP_REG_EN
      obs_resp  = resp;
      obs_rdata = rdata;
      chk("resp", resp, mem_resp);
      chk("rdata", rdata, mem_rdata);
`endif
      @(posedge clk);
      if (mem_resp != NOTRDY) begin
         if (oq.size() == 0) exp_unexp = 1'b1;
         else void'(oq.pop_front());
      end
      if (do_pop) oq.push_back(fq.pop_front());
      if (exp_ack) fq.push_back(cur);
      prev_resp  = mem_resp;
      prev_rdata = mem_rdata;
      #1;
      chk("mem_req", mem_req, fq.size() != 0);
      if (fq.size() != 0) begin
         chk("mem_addr", mem_addr, fq[0].addr);
         chk("mem_cmd", mem_cmd, fq[0].cmd);
         chk("mem_width", mem_width, fq[0].width);
         chk("mem_wdata", mem_wdata, fq[0].wdata);
      end
      chk("unexp_resp", unexp_resp, exp_unexp);
`ifdef YCR_DCACHE_PIPE_RESP_REG_EN
      obs_resp  = resp;
      obs_rdata = rdata;
      chk("resp_reg", resp, prev_resp);
      chk("rdata_reg", rdata, prev_rdata);
`endif
   endtask

   task automatic idle(input logic mack, input logic [1:0] mresp);
      set_in(1'b0, 1'b0, 2'b00, '0, '0, mack, mresp, DW'($urandom));
      cycle();
   endtask

   task automatic drain();
      for (int k = 0; k < 24 && (fq.size() != 0 || oq.size() != 0); k++)
         idle(1'b1, (oq.size() != 0) ? RDY_OK : NOTRDY);
      idle(1'b0, NOTRDY);
      chk("drain_mem_req", mem_req, 1'b0);
   endtask

   task automatic single_read(input logic [AW-1:0] a, input string tag);
      set_in(1'b1, 1'b0, 2'b10, a, '0, 1'b0, NOTRDY, '0);
      cycle();
      chk({tag, "_ack"}, obs_ack, 1'b1);
      chk({tag, "_mem_req"}, mem_req, 1'b1);
      chk({tag, "_mem_addr"}, mem_addr, a);
      idle(1'b1, NOTRDY);
      set_in(1'b0, 1'b0, 2'b00, '0, '0, 1'b0, RDY_OK, 32'hDEAD_BEEF);
      cycle();
      chk({tag, "_resp"}, obs_resp, RDY_OK);
      chk({tag, "_rdata"}, obs_rdata, 32'hDEAD_BEEF);
      idle(1'b0, NOTRDY);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_req_ack", req_ack, 1'b0);
      chk("rst_resp", resp, NOTRDY);
      chk("rst_rdata", rdata, '0);
      chk("rst_mem_addr", mem_addr, '0);
      chk("rst_mem_cmd", mem_cmd, 1'b0);
      chk("rst_mem_width", mem_width, 2'b00);
      chk("rst_mem_wdata", mem_wdata, '0);
      chk("rst_unexp", unexp_resp, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      single_read(32'h0000_1000, "sr");

      // Backpressure fill: cache never accepts, third request is refused.
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 1'b0, 2'b10, 32'h100 + 4 * i, DW'($urandom), 1'b0, NOTRDY, '0);
         cycle();
         acks[i] = obs_ack;
         chk("bp_hold_addr", mem_addr, 32'h100);
      end
      chk("bp_ack0", acks[0], 1'b1);
      chk("bp_ack1", acks[1], 1'b1);
      chk("bp_ack2", acks[2], 1'b0);
      drain();

      // MAX_PEND: cache accepts everything, returns nothing.
      for (int i = 0; i < 6; i++) begin
         set_in(1'b1, 1'b0, 2'b10, 32'h200 + 4 * i, '0, 1'b1, NOTRDY, '0);
         cycle();
         acks[i] = obs_ack;
      end
      chk("mp_ack3", acks[3], 1'b1);
      chk("mp_ack4", acks[4], 1'b0);
      chk("mp_ack5", acks[5], 1'b0);
      set_in(1'b1, 1'b0, 2'b10, 32'h300, '0, 1'b1, RDY_OK, 32'h1);
      cycle();
      chk("mp_same_cycle", obs_ack, 1'b0);
      set_in(1'b1, 1'b0, 2'b10, 32'h300, '0, 1'b1, NOTRDY, '0);
      cycle();
      chk("mp_freed", obs_ack, 1'b1);
      drain();

      // Push, pop and completion together with fifo_cnt=1, outstanding=1.
      set_in(1'b1, 1'b0, 2'b10, 32'h10, '0, 1'b0, NOTRDY, '0); cycle();
      set_in(1'b1, 1'b0, 2'b10, 32'h20, '0, 1'b1, NOTRDY, '0); cycle();
      set_in(1'b1, 1'b0, 2'b10, 32'h30, '0, 1'b1, RDY_OK, 32'h10); cycle();
      chk("sim_ack", obs_ack, 1'b1);
      chk("sim_head", mem_addr, 32'h30);
      set_in(1'b1, 1'b0, 2'b10, 32'h40, '0, 1'b0, NOTRDY, '0); cycle();
      chk("sim_cnt1_ack", obs_ack, 1'b1);
      set_in(1'b1, 1'b0, 2'b10, 32'h50, '0, 1'b0, NOTRDY, '0); cycle();
      chk("sim_full_ack", obs_ack, 1'b0);
      drain();

      // Error response on a write, then an unexpected response.
      set_in(1'b1, 1'b1, 2'b10, 32'h400, 32'h1234_5678, 1'b0, NOTRDY, '0); cycle();
      chk("er_mem_cmd", mem_cmd, 1'b1);
      idle(1'b1, NOTRDY);
      set_in(1'b0, 1'b0, 2'b00, '0, '0, 1'b0, RDY_ER, 32'h0BAD);
      cycle();
      chk("er_resp", obs_resp, RDY_ER);
      idle(1'b0, NOTRDY);
      set_in(1'b0, 1'b0, 2'b00, '0, '0, 1'b0, RDY_OK, 32'h5);
      cycle();
      chk("ux_resp", obs_resp, RDY_OK);
      chk("ux_set", unexp_resp, 1'b1);
      idle(1'b0, NOTRDY);
      idle(1'b0, NOTRDY);
      chk("ux_sticky", unexp_resp, 1'b1);

      // Reset with two queued and one outstanding.
      set_in(1'b1, 1'b0, 2'b10, 32'hA0, '0, 1'b0, NOTRDY, '0); cycle();
      set_in(1'b1, 1'b0, 2'b10, 32'hB0, '0, 1'b1, NOTRDY, '0); cycle();
      set_in(1'b1, 1'b0, 2'b10, 32'hC0, '0, 1'b0, NOTRDY, '0); cycle();
      chk("mr_full", mem_req, 1'b1);
      set_in(1'b1, 1'b0, 2'b10, 32'hD0, '0, 1'b0, NOTRDY, '0);
      rst_n = 1'b0;
      #1;
      chk("mr_mem_req", mem_req, 1'b0);
      chk("mr_req_ack", req_ack, 1'b0);
      chk("mr_unexp", unexp_resp, 1'b0);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      req = 1'b0;
      single_read(32'h0000_2000, "mr_sr");

      // Randomized traffic.
      for (int n = 0; n < 300; n++) begin
         logic [1:0] r;
         r = NOTRDY;
         if (oq.size() != 0 && ($urandom % 3) == 0) r = (($urandom % 4) == 0) ? RDY_ER : RDY_OK;
         set_in(1'($urandom), 1'($urandom), 2'($urandom), AW'($urandom), DW'($urandom),
                1'($urandom), r, DW'($urandom));
         cycle();
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
